lif_neuron_array: RTL and testbench
===================================

// Module: lif_neuron_array
// PURPOSE
//  - Array of N independent current-based leaky integrate-and-fire neurons, parametrised in width and count.
//  - Each neuron keeps a synaptic-current register and a membrane register, updated on a shared step strobe.
//  - Each neuron fires a one-cycle spike when its membrane reaches threshold.
//  - Fits between the tt_um_* top (ui_in/uio pin mapping) and downstream spike consumers.
//  - Also provides a registered membrane readout for monitoring.
// PARAMETERS
//  N_NEURONS    4    number of neurons; >=1
//  WIDTH        8    bits of current and membrane registers and of each input current
//  THRESH       200  firing threshold (unsigned, < 2**WIDTH)
//  LEAK_SHIFT   1    membrane leak: mem - (mem >> LEAK_SHIFT)
//  CUR_SHIFT    2    current decay: cur - (cur >> CUR_SHIFT)
//  RESET_MODE   0    post-spike membrane: 0 = clear to 0, 1 = subtract THRESH
//  REFRAC_STEPS 2    refractory length in steps; used only with LIF_REFRACTORY_EN
// PORTS
//  clk          in   1                  clock; all state updates on rising edge
//  rst          in   1                  asynchronous, active-high reset
//  step         in   1                  update strobe; one integration step per cycle it is high
//  in_current   in   N_NEURONS*WIDTH    neuron n input = in_current[n*WIDTH +: WIDTH], sampled when step=1
//  spike        out  N_NEURONS          registered one-cycle spike pulses, bit n = neuron n
//  state_sel    in   clog2(N_NEURONS)   neuron index for readout (max(1,.) bits)
//  state_out    out  WIDTH              registered membrane of neuron state_sel
// BEHAVIOUR
//  - Reset: while rst=1, asynchronously:
//    - all cur, mem, spike, state_out = 0
//    - refractory counters = 0
//  - Reset mid-step aborts that step; no partial update survives.
//  - step=0:
//    - cur, mem and refractory counters hold
//    - spike = 0 next cycle
//    - state_out keeps tracking the selection
//  - step=1, per neuron n, all neurons in parallel, unsigned arithmetic in WIDTH+1 bits:
//    - cur_nx = sat(cur - (cur>>CUR_SHIFT) + in_n)
//    - mem_nx = sat(mem - (mem>>LEAK_SHIFT) + cur_nx)
//    - sat() clamps to 2**WIDTH-1; results never wrap
//    - if mem_nx >= THRESH: spike[n]=1 the next cycle; mem <= (RESET_MODE ? mem_nx-THRESH : 0)
//    - else: spike[n]=0; mem <= mem_nx
//    - cur <= cur_nx always
//  - Latency:
//    - spike is valid the cycle after the step edge and lasts exactly 1 cycle, even for back-to-back steps
//    - state_out = mem[state_sel] registered: 1 cycle after a sel change or a mem update
//  - Boundaries:
//    - state_sel >= N_NEURONS: state_out = 0
//    - mem saturated at 2**WIDTH-1 with THRESH below it: fires every step
//    - THRESH=0: every step fires
// CONFIGURATION
//  LIF_REFRACTORY_EN defined:
//    - per-neuron counter loaded with REFRAC_STEPS on each spike; decremented once per step while nonzero
//    - while nonzero: mem forced 0 on step, spike suppressed, cur still integrates
//    - counter reaching 0 on a step: that same step integrates normally
//    - REFRAC_STEPS=0: identical to undefined
//  LIF_REFRACTORY_EN undefined:
//    - no counters instantiated; a neuron may fire on consecutive steps
// TESTING (defaults, macro off unless noted)
//  1. rst pulse, then in_current=0, step=1 for 10 cycles -> spike=0, all mem and state_out = 0.
//  2. Neuron 0 input 100, others 0, step each cycle:
//     - step1: cur=100, mem=100
//     - step2: cur=175, mem=225 -> spike[0]=1 one cycle, then mem=0
//     - RESET_MODE=1 run: mem=25 after step2
//  3. All inputs 255 continuously -> cur and mem saturate at 255, no wrap; spike=4'b1111 every cycle after first fire.
//  4. Neuron 1 mid-integration, step dropped to 0 for 5 cycles -> mem/cur/state_out frozen, spike=0; resumes on step=1.
//  5. LIF_REFRACTORY_EN, input 100 on neuron 0, spike on step2:
//     - steps 3-4: mem=0, no spike; cur continues (step3 cur=232)
//     - step5: integrates normally again
//  6. rst asserted asynchronously between edges during case 3 -> spike, state_out, all registers 0 before the next clk edge.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Array of current-based leaky integrate-and-fire neurons stepped by a shared strobe.
// Optional feature macro: LIF_REFRACTORY_EN adds per-neuron refractory counters.
module lif_neuron_array #(
    parameter int unsigned N_NEURONS    = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned THRESH       = 200,
    parameter int unsigned LEAK_SHIFT   = 1,
    parameter int unsigned CUR_SHIFT    = 2,
    parameter int unsigned RESET_MODE   = 0,
    parameter int unsigned REFRAC_STEPS = 2,
    localparam int unsigned SEL_W       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       step_i,
    input  logic [N_NEURONS*WIDTH-1:0] in_current_i,
    input  logic [SEL_W-1:0]           state_sel_i,
    output logic [N_NEURONS-1:0]       spike_o,
    output logic [WIDTH-1:0]           state_out_o
);

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

    logic [WIDTH-1:0]     cur_q [N_NEURONS];
    logic [WIDTH-1:0]     cur_d [N_NEURONS];
    logic [WIDTH-1:0]     mem_q [N_NEURONS];
    logic [WIDTH-1:0]     mem_d [N_NEURONS];
    logic [WIDTH-1:0]     cur_nx [N_NEURONS];
    logic [WIDTH-1:0]     mem_nx [N_NEURONS];
    logic [N_NEURONS-1:0] spike_q, spike_d;
    logic [WIDTH-1:0]     state_out_q, state_out_d;

`ifdef LIF_REFRACTORY_EN
    localparam int unsigned RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    logic [RC_W-1:0] rc_q [N_NEURONS];
    logic [RC_W-1:0] rc_d [N_NEURONS];
`endif

    // Sums of two WIDTH-bit values fit in WIDTH+1 bits, so the carry flags saturation.
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] v);
        return v[WIDTH] ? '1 : v[WIDTH-1:0];
    endfunction

    always_comb begin
        for (int n = 0; n < N_NEURONS; n++) begin
            cur_nx[n] = sat({1'b0, cur_q[n] - (cur_q[n] >> CUR_SHIFT)}
                            + {1'b0, in_current_i[n*WIDTH +: WIDTH]});
            mem_nx[n] = sat({1'b0, mem_q[n] - (mem_q[n] >> LEAK_SHIFT)} + {1'b0, cur_nx[n]});
        end
    end

    always_comb begin
        spike_d = '0;
        for (int n = 0; n < N_NEURONS; n++) begin
            cur_d[n] = cur_q[n];
            mem_d[n] = mem_q[n];
`ifdef LIF_REFRACTORY_EN
            rc_d[n] = rc_q[n];
`endif
            if (step_i) begin
                cur_d[n] = cur_nx[n];
`ifdef LIF_REFRACTORY_EN
                // Refractory neurons keep integrating current but hold the membrane at rest.
                if (rc_q[n] != '0) begin
                    rc_d[n]  = rc_q[n] - RC_W'(1);
                    mem_d[n] = '0;
                end else
`endif
                if (mem_nx[n] >= THR) begin
                    spike_d[n] = 1'b1;
                    mem_d[n]   = (RESET_MODE != 0) ? mem_nx[n] - THR : '0;
`ifdef LIF_REFRACTORY_EN
                    rc_d[n] = RC_W'(REFRAC_STEPS);
`endif
                end else begin
                    mem_d[n] = mem_nx[n];
                end
            end
        end
    end

    always_comb begin
        state_out_d = '0;
        if (32'(state_sel_i) < N_NEURONS) begin
            state_out_d = mem_q[state_sel_i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                cur_q[n] <= '0;
                mem_q[n] <= '0;
`ifdef LIF_REFRACTORY_EN
                rc_q[n] <= '0;
`endif
            end
            spike_q     <= '0;
            state_out_q <= '0;
        end else begin
            for (int n = 0; n < N_NEURONS; n++) begin
                cur_q[n] <= cur_d[n];
                mem_q[n] <= mem_d[n];
`ifdef LIF_REFRACTORY_EN
                rc_q[n] <= rc_d[n];
`endif
            end
            spike_q     <= spike_d;
            state_out_q <= state_out_d;
        end
    end

    assign spike_o     = spike_q;
    assign state_out_o = state_out_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomised bench for lif_neuron_array against an integer-arithmetic neuron model.
module tb_lif_neuron_array;

    localparam int N      = 4;
    localparam int W      = 8;
    localparam int THRESH = 200;
    localparam int LEAK   = 1;
    localparam int CSH    = 2;
    localparam int RMODE  = 0;
    localparam int REFRAC = 2;
    localparam int MAXV   = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         step = 1'b0;
    logic [N*W-1:0] in_cur = '0;
    logic [1:0]   sel = '0;
    logic [N-1:0] spike;
    logic [W-1:0] so;

    lif_neuron_array dut (
        .clk         (clk),
        .rst         (rst),
        .step_i      (step),
        .in_current_i(in_cur),
        .state_sel_i (sel),
        .spike_o     (spike),
        .state_out_o (so)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int m_cur [N];
    int m_mem [N];
    int m_rc  [N];
    int m_spike = 0;
    int m_so    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_cur[n] = 0;
            m_mem[n] = 0;
            m_rc[n]  = 0;
        end
        m_spike = 0;
        m_so    = 0;
    endtask

    // One clock edge of the array: readout sees the pre-edge membrane.
    task automatic model_edge(input bit st, input logic [N*W-1:0] inv, input int s);
        m_so    = (s < N) ? m_mem[s] : 0;
        m_spike = 0;
        if (!st) return;
        for (int n = 0; n < N; n++) begin
            int c;
            int m;
            c = sat(m_cur[n] - m_cur[n] / (1 << CSH) + int'(inv[n*W +: W]));
            m = sat(m_mem[n] - m_mem[n] / (1 << LEAK) + c);
            m_cur[n] = c;
`ifdef LIF_REFRACTORY_EN
            if (m_rc[n] > 0) begin
                m_rc[n]  = m_rc[n] - 1;
                m_mem[n] = 0;
                continue;
            end
`endif
            if (m >= THRESH) begin
                m_spike  = m_spike | (1 << n);
                m_mem[n] = RMODE ? m - THRESH : 0;
                m_rc[n]  = REFRAC;
            end else begin
                m_mem[n] = m;
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_edge(step, in_cur, int'(sel));
        #1;
        if (!rst) begin
            check("spike", int'(spike), m_spike);
            check("state_out", int'(so), m_so);
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp5 [5];

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Zero input: nothing moves.
        step = 1'b1;
        in_cur = '0;
        repeat (10) @(negedge clk);
        check("c1_spike", int'(spike), 0);
        step = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = 2'(s);
            @(negedge clk);
            check("c1_mem_readout", int'(so), 0);
        end

        // Single neuron integrates to threshold on the second step.
        pulse_reset();
        sel = 2'd0;
        in_cur = '0;
        in_cur[7:0] = 8'd100;
        step = 1'b1;
        @(negedge clk);
        check("c2_spike_step1", int'(spike), 0);
        check("c2_model_cur1", m_cur[0], 100);
        check("c2_model_mem1", m_mem[0], 100);
        @(negedge clk);
        check("c2_spike_step2", int'(spike), 1);
        check("c2_state_out_step2", int'(so), 100);
        check("c2_model_cur2", m_cur[0], 175);
        check("c2_model_mem2", m_mem[0], 0);
        step = 1'b0;
        @(negedge clk);
        check("c2_spike_gone", int'(spike), 0);
        check("c2_state_out_cleared", int'(so), 0);

        // Freeze while step is low, then resume.
        pulse_reset();
        sel = 2'd1;
        in_cur = '0;
        in_cur[15:8] = 8'd60;
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("c4_frozen_state_out", int'(so), 135);
            check("c4_frozen_spike", int'(spike), 0);
        end
        step = 1'b1;
        in_cur = '0;
        @(negedge clk);
        check("c4_resume_old", int'(so), 135);
        step = 1'b0;
        @(negedge clk);
        check("c4_resume_new", int'(so), 147);

        // Refractory behaviour (or consecutive firing without it).
        pulse_reset();
        sel = 2'd0;
        in_cur = '0;
        in_cur[7:0] = 8'd100;
`ifdef LIF_REFRACTORY_EN
        exp5 = '{0, 1, 0, 0, 1};
`else
        exp5 = '{0, 1, 1, 1, 1};
`endif
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("c5_spike_seq", int'(spike[0]), exp5[i]);
        end
        check("c5_model_cur_sat", m_cur[0], 255);
        step = 1'b0;

        // Full-scale drive saturates and fires every step; then async reset mid-cycle.
        pulse_reset();
        in_cur = '1;
        step = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("c3_all_fire", int'(spike), 15);
        end
        check("c3_model_cur_sat", m_cur[2], 255);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("c6_async_spike", int'(spike), 0);
        check("c6_async_state_out", int'(so), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) == 0);
            step = ($urandom_range(0, 3) != 0);
            sel  = 2'($urandom_range(0, N - 1));
            for (int n = 0; n < N; n++) begin
                case ($urandom_range(0, 3))
                    0:       in_cur[n*W +: W] = '0;
                    1:       in_cur[n*W +: W] = 8'($urandom_range(0, 40));
                    2:       in_cur[n*W +: W] = 8'hFF;
                    default: in_cur[n*W +: W] = 8'($urandom_range(0, 255));
                endcase
            end
        end
        @(negedge clk);
        rst = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
